// File: rtl/mips_fetch_unit_pkg.sv
// Shared single-cycle MIPS definitions: opcode field encodings, fetch FSM states
// and the NOP instruction word.
package MIPS_SC_Definitions;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE  = 2'd0;
  localparam fetch_state_t FETCH = 2'd1;
  localparam fetch_state_t HOLD  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_unit_next_pc.sv
// Next-PC selection for the fetch stage: jump beats taken branch beats sequential.
module mips_next_pc
  import MIPS_SC_Definitions::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] jindex_i,
  input  logic        jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  // J-type target keeps the region bits of the delay-slot address.
  assign jump_pc   = {pc_plus4_i[31:28], jindex_i, 2'b00};
  assign branch_pc = branch_target_i & 32'hFFFF_FFFC;

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i) begin
      next_pc_o = jump_pc;
    end else if (branch_taken_i) begin
      next_pc_o = branch_pc;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC register, imem request/valid handshake and a
// one-entry instruction holding register presented to decode.
module mips_fetch_unit
  import MIPS_SC_Definitions::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output opcode_t     opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_w;
  logic [31:0]  next_pc_w;

  assign pc_plus4_w = pc_q + 32'd4;

  mips_next_pc u_next_pc (
    .pc_plus4_i      (pc_plus4_w),
    .jindex_i        (instr_q[25:0]),
    .jump_i          (jump),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc_w)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Redirect inputs only matter on the consume edge.
        if (instr_ready) begin
          pc_d    = next_pc_w;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign opcode      = opcode_t'(instr_q[31:26]);
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;

endmodule
